// File: rtl/sram_controller_pkg.sv
// Shared definitions for the MEM-stage external SRAM controller.
package sram_controller_pkg;

  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

  localparam logic [31:0] BASE_ADDR   = 32'd1024;
  localparam int          SRAM_ADDR_W = 18;
  localparam int          SRAM_DATA_W = 16;

endpackage

// File: rtl/sram_controller.sv
// Splits a 32-bit pipeline load/store into two 16-bit asynchronous SRAM
// accesses, stalling the pipeline through ready until the word completes.
module sram_controller
  import sram_controller_pkg::state_t, sram_controller_pkg::IDLE, sram_controller_pkg::LOW,
         sram_controller_pkg::HIGH, sram_controller_pkg::DONE,
         sram_controller_pkg::SRAM_ADDR_W, sram_controller_pkg::SRAM_DATA_W;
#(
  parameter logic [31:0] BASE_ADDR    = sram_controller_pkg::BASE_ADDR,
  parameter int unsigned PHASE_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic                   rd_en,
  input  logic [31:0]            address,
  input  logic [31:0]            write_data,
  output logic [31:0]            read_data,
  output logic                   ready,
  output logic [SRAM_ADDR_W-1:0] sram_addr,
  output logic [SRAM_DATA_W-1:0] sram_dq_out,
  output logic                   sram_dq_oe,
  input  logic [SRAM_DATA_W-1:0] sram_dq_in,
  output logic                   sram_we_n,
  output logic                   sram_oe_n,
  output logic                   sram_ce_n,
  output logic                   sram_ub_n,
  output logic                   sram_lb_n
);

  localparam int WORD_W = SRAM_ADDR_W - 1;
  localparam int CNT_W  = (PHASE_CYCLES > 1) ? $clog2(PHASE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PHASE_CYCLES - 1);

  state_t                 state;
  logic [CNT_W-1:0]       cnt;
  logic                   op_write;
  logic [WORD_W-1:0]      word;
  logic [31:0]            wdata;
  logic                   request;
  logic                   last_phase;

  assign request    = wr_en | rd_en;
  assign last_phase = (cnt == LAST_CNT);

  assign sram_ce_n = 1'b0;
  assign sram_ub_n = 1'b0;
  assign sram_lb_n = 1'b0;

  assign ready = ((state == IDLE) && !request) || (state == DONE);

  // Only the values latched on acceptance are used; the pipeline holds its
  // request stable while stalled, but the controller does not rely on it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      op_write  <= 1'b0;
      word      <= '0;
      wdata     <= '0;
      read_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (request) begin
            op_write <= wr_en;
            word     <= WORD_W'((address - BASE_ADDR) >> 2);
            wdata    <= write_data;
            cnt      <= '0;
            state    <= LOW;
          end
        end
        LOW: begin
          if (last_phase) begin
            if (!op_write) read_data[SRAM_DATA_W-1:0] <= sram_dq_in;
            cnt   <= '0;
            state <= HIGH;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HIGH: begin
          if (last_phase) begin
            if (!op_write) read_data[2*SRAM_DATA_W-1:SRAM_DATA_W] <= sram_dq_in;
            cnt   <= '0;
            state <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The half select doubles as the SRAM address LSB.
  always_comb begin
    sram_addr   = '0;
    sram_dq_out = '0;
    sram_dq_oe  = 1'b0;
    sram_we_n   = 1'b1;
    sram_oe_n   = 1'b1;
    if ((state == LOW) || (state == HIGH)) begin
      sram_addr = {word, (state == HIGH)};
      if (op_write) begin
        sram_we_n   = 1'b0;
        sram_dq_oe  = 1'b1;
        sram_dq_out = (state == HIGH) ? wdata[2*SRAM_DATA_W-1:SRAM_DATA_W]
                                      : wdata[SRAM_DATA_W-1:0];
      end else begin
        sram_oe_n = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sram_controller.sv
// Scoreboard bench for sram_controller: default build plus a PHASE_CYCLES=1
// build, each wired to its own behavioural SRAM.
module tb_sram_controller;

  typedef struct packed {
    logic [17:0] addr;
    logic [15:0] dq;
    logic        we_n;
    logic        oe_n;
    logic        dq_oe;
    logic        ready;
  } sig_t;

  typedef struct {
    sig_t s;
    bit   chk_dq;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic        wr_en0 = 1'b0, rd_en0 = 1'b0;
  logic [31:0] address0 = '0, write_data0 = '0, read_data0;
  logic        ready0, dq_oe0, we_n0, oe_n0, ce_n0, ub_n0, lb_n0;
  logic [17:0] sram_addr0;
  logic [15:0] dq_out0, dq_in0;

  logic        wr_en1 = 1'b0, rd_en1 = 1'b0;
  logic [31:0] address1 = '0, write_data1 = '0, read_data1;
  logic        ready1, dq_oe1, we_n1, oe_n1, ce_n1, ub_n1, lb_n1;
  logic [17:0] sram_addr1;
  logic [15:0] dq_out1, dq_in1;

  logic [15:0] mem0 [64] = '{default: 16'h0};
  logic [15:0] mem1 [64] = '{default: 16'h0};
  logic [15:0] ref0 [64] = '{default: 16'h0};
  logic [15:0] ref1 [64] = '{default: 16'h0};
  logic [31:0] exp_rd0 = '0, exp_rd1 = '0;

  logic        pre_en = 1'b0, pre_sel = 1'b0;
  logic [5:0]  pre_a = '0;
  logic [15:0] pre_d = '0;

  exp_t expq [$];
  exp_t e;
  sig_t o, m, idle_rdy;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  sram_controller dut (
    .clk(clk), .rst(rst), .wr_en(wr_en0), .rd_en(rd_en0), .address(address0),
    .write_data(write_data0), .read_data(read_data0), .ready(ready0),
    .sram_addr(sram_addr0), .sram_dq_out(dq_out0), .sram_dq_oe(dq_oe0),
    .sram_dq_in(dq_in0), .sram_we_n(we_n0), .sram_oe_n(oe_n0),
    .sram_ce_n(ce_n0), .sram_ub_n(ub_n0), .sram_lb_n(lb_n0)
  );

  sram_controller #(.PHASE_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .wr_en(wr_en1), .rd_en(rd_en1), .address(address1),
    .write_data(write_data1), .read_data(read_data1), .ready(ready1),
    .sram_addr(sram_addr1), .sram_dq_out(dq_out1), .sram_dq_oe(dq_oe1),
    .sram_dq_in(dq_in1), .sram_we_n(we_n1), .sram_oe_n(oe_n1),
    .sram_ce_n(ce_n1), .sram_ub_n(ub_n1), .sram_lb_n(lb_n1)
  );

  // Behavioural SRAMs: write on edges where we_n is low, read combinationally.
  always @(posedge clk) begin
    if (pre_en && !pre_sel) mem0[pre_a] <= pre_d;
    else if (!we_n0) mem0[sram_addr0[5:0]] <= dq_out0;
    if (pre_en && pre_sel) mem1[pre_a] <= pre_d;
    else if (!we_n1) mem1[sram_addr1[5:0]] <= dq_out1;
  end

  assign dq_in0 = oe_n0 ? 16'h0 : mem0[sram_addr0[5:0]];
  assign dq_in1 = oe_n1 ? 16'h0 : mem1[sram_addr1[5:0]];

  function automatic sig_t sample(input bit sel);
    sig_t s;
    if (sel) s = '{addr: sram_addr1, dq: dq_out1, we_n: we_n1, oe_n: oe_n1, dq_oe: dq_oe1, ready: ready1};
    else     s = '{addr: sram_addr0, dq: dq_out0, we_n: we_n0, oe_n: oe_n0, dq_oe: dq_oe0, ready: ready0};
    return s;
  endfunction

  task automatic preload(input bit sel, input logic [5:0] a, input logic [15:0] d);
    @(posedge clk); #1;
    pre_en = 1'b1; pre_sel = sel; pre_a = a; pre_d = d;
    @(posedge clk); #1;
    pre_en = 1'b0;
    if (sel) ref1[a] = d; else ref0[a] = d;
  endtask

  task automatic release_req();
    wr_en0 = 1'b0; rd_en0 = 1'b0; wr_en1 = 1'b0; rd_en1 = 1'b0;
  endtask

  // Drives one request in the next IDLE cycle and queues the per-cycle pin
  // behaviour expected from it, ending with the DONE cycle.
  task automatic drive_request(input bit sel, input logic wr, input logic rd,
                               input logic [31:0] a, input logic [31:0] d);
    logic [16:0] w;
    logic [5:0]  i0, i1;
    exp_t        x;
    int          pc;
    pc = sel ? 1 : 2;
    w  = 17'((a - 32'd1024) >> 2);
    i0 = {w[4:0], 1'b0};
    i1 = {w[4:0], 1'b1};
    @(posedge clk); #1;
    if (sel) begin wr_en1 = wr; rd_en1 = rd; address1 = a; write_data1 = d; end
    else     begin wr_en0 = wr; rd_en0 = rd; address0 = a; write_data0 = d; end
    x.chk_dq = 1'b0;
    x.s = '{addr: 18'd0, dq: 16'd0, we_n: 1'b1, oe_n: 1'b1, dq_oe: 1'b0, ready: 1'b0};
    expq.push_back(x);
    for (int h = 0; h < 2; h++) begin
      for (int k = 0; k < pc; k++) begin
        x.s.addr  = {w, h[0]};
        x.s.ready = 1'b0;
        if (wr) begin
          x.chk_dq = 1'b1; x.s.dq = (h != 0) ? d[31:16] : d[15:0];
          x.s.we_n = 1'b0; x.s.oe_n = 1'b1; x.s.dq_oe = 1'b1;
        end else begin
          x.chk_dq = 1'b0; x.s.dq = 16'd0;
          x.s.we_n = 1'b1; x.s.oe_n = 1'b0; x.s.dq_oe = 1'b0;
        end
        expq.push_back(x);
      end
    end
    x.chk_dq = 1'b0;
    x.s = '{addr: 18'd0, dq: 16'd0, we_n: 1'b1, oe_n: 1'b1, dq_oe: 1'b0, ready: 1'b1};
    expq.push_back(x);
    if (wr) begin
      if (sel) begin ref1[i0] = d[15:0]; ref1[i1] = d[31:16]; end
      else     begin ref0[i0] = d[15:0]; ref0[i1] = d[31:16]; end
    end else begin
      if (sel) exp_rd1 = {ref1[i1], ref1[i0]};
      else     exp_rd0 = {ref0[i1], ref0[i0]};
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    release_req();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    o = sample(0);
    n_checks++;
    if (o !== idle_rdy) begin n_fail++; $display("[TB] FAIL reset_pins0: got %h, want %h", o, idle_rdy); end
    o = sample(1);
    n_checks++;
    if (o !== idle_rdy) begin n_fail++; $display("[TB] FAIL reset_pins1: got %h, want %h", o, idle_rdy); end
    n_checks++;
    if ({read_data0, read_data1} !== 64'd0) begin
      n_fail++; $display("[TB] FAIL reset_rdata: got %h %h, want 0 0", read_data0, read_data1);
    end
    n_checks++;
    if ({ce_n0, ub_n0, lb_n0, ce_n1, ub_n1, lb_n1} !== 6'b0) begin
      n_fail++; $display("[TB] FAIL select_pins: got %b, want 000000", {ce_n0, ub_n0, lb_n0, ce_n1, ub_n1, lb_n1});
    end
  endtask

  task automatic test_read();
    preload(0, 6'd2, 16'h5678);
    preload(0, 6'd3, 16'h1234);
    drive_request(0, 1'b0, 1'b1, 32'd1028, 32'd0);
    while (expq.size() != 0) begin
      @(negedge clk);
      e = expq.pop_front(); o = sample(0); m = '1; if (!e.chk_dq) m.dq = '0;
      n_checks++;
      if ((o & m) !== (e.s & m)) begin n_fail++; $display("[TB] FAIL read_seq: got %h, want %h", o, e.s); end
      if (e.s.ready) begin
        n_checks++;
        if (read_data0 !== exp_rd0) begin n_fail++; $display("[TB] FAIL read_data: got %h, want %h", read_data0, exp_rd0); end
      end
    end
    drive_request(0, 1'b0, 1'b1, 32'd1031, 32'd0);
    while (expq.size() != 0) begin
      @(negedge clk);
      e = expq.pop_front(); o = sample(0); m = '1; if (!e.chk_dq) m.dq = '0;
      n_checks++;
      if ((o & m) !== (e.s & m)) begin n_fail++; $display("[TB] FAIL read_lowbits_seq: got %h, want %h", o, e.s); end
      if (e.s.ready) begin
        n_checks++;
        if (read_data0 !== exp_rd0) begin n_fail++; $display("[TB] FAIL read_lowbits_data: got %h, want %h", read_data0, exp_rd0); end
      end
    end
    release_req();
  endtask

  task automatic test_write();
    drive_request(0, 1'b1, 1'b0, 32'd1028, 32'hDEADBEEF);
    while (expq.size() != 0) begin
      @(negedge clk);
      e = expq.pop_front(); o = sample(0); m = '1; if (!e.chk_dq) m.dq = '0;
      n_checks++;
      if ((o & m) !== (e.s & m)) begin n_fail++; $display("[TB] FAIL write_seq: got %h, want %h", o, e.s); end
      if (e.s.ready) begin
        n_checks++;
        if (read_data0 !== exp_rd0) begin n_fail++; $display("[TB] FAIL write_keeps_rdata: got %h, want %h", read_data0, exp_rd0); end
      end
    end
    release_req();
  endtask

  task automatic test_write_wins();
    drive_request(0, 1'b1, 1'b1, 32'd1024, 32'hA5A50F0F);
    while (expq.size() != 0) begin
      @(negedge clk);
      e = expq.pop_front(); o = sample(0); m = '1; if (!e.chk_dq) m.dq = '0;
      n_checks++;
      if ((o & m) !== (e.s & m)) begin n_fail++; $display("[TB] FAIL both_seq: got %h, want %h", o, e.s); end
      if (e.s.ready) begin
        n_checks++;
        if (read_data0 !== exp_rd0) begin n_fail++; $display("[TB] FAIL both_rdata: got %h, want %h", read_data0, exp_rd0); end
      end
    end
    release_req();
  endtask

  task automatic test_back_to_back();
    drive_request(0, 1'b1, 1'b0, 32'd1032, 32'h13579BDF);
    while (expq.size() != 0) begin
      @(negedge clk);
      e = expq.pop_front(); o = sample(0); m = '1; if (!e.chk_dq) m.dq = '0;
      n_checks++;
      if ((o & m) !== (e.s & m)) begin n_fail++; $display("[TB] FAIL b2b_write_seq: got %h, want %h", o, e.s); end
    end
    drive_request(0, 1'b0, 1'b1, 32'd1032, 32'd0);
    while (expq.size() != 0) begin
      @(negedge clk);
      e = expq.pop_front(); o = sample(0); m = '1; if (!e.chk_dq) m.dq = '0;
      n_checks++;
      if ((o & m) !== (e.s & m)) begin n_fail++; $display("[TB] FAIL b2b_read_seq: got %h, want %h", o, e.s); end
      if (e.s.ready) begin
        n_checks++;
        if (read_data0 !== exp_rd0) begin n_fail++; $display("[TB] FAIL b2b_read_data: got %h, want %h", read_data0, exp_rd0); end
      end
    end
    release_req();
  endtask

  task automatic test_wrap();
    drive_request(0, 1'b1, 1'b0, 32'd525312, 32'h0BADC0DE);
    while (expq.size() != 0) begin
      @(negedge clk);
      e = expq.pop_front(); o = sample(0); m = '1; if (!e.chk_dq) m.dq = '0;
      n_checks++;
      if ((o & m) !== (e.s & m)) begin n_fail++; $display("[TB] FAIL wrap_write_seq: got %h, want %h", o, e.s); end
    end
    drive_request(0, 1'b0, 1'b1, 32'd1024, 32'd0);
    while (expq.size() != 0) begin
      @(negedge clk);
      e = expq.pop_front(); o = sample(0); m = '1; if (!e.chk_dq) m.dq = '0;
      n_checks++;
      if ((o & m) !== (e.s & m)) begin n_fail++; $display("[TB] FAIL wrap_read_seq: got %h, want %h", o, e.s); end
      if (e.s.ready) begin
        n_checks++;
        if (read_data0 !== exp_rd0) begin n_fail++; $display("[TB] FAIL wrap_read_data: got %h, want %h", read_data0, exp_rd0); end
      end
    end
    release_req();
  endtask

  task automatic test_reset_mid_access();
    drive_request(0, 1'b1, 1'b0, 32'd1036, 32'hCAFEF00D);
    expq.delete();
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({sram_addr0, we_n0} !== {18'd7, 1'b0}) begin
      n_fail++; $display("[TB] FAIL mid_high_phase: got addr %h we_n %b, want addr 7 we_n 0", sram_addr0, we_n0);
    end
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    release_req();
    exp_rd0 = 32'd0;
    exp_rd1 = 32'd0;
    @(negedge clk);
    o = sample(0);
    n_checks++;
    if (o !== idle_rdy) begin n_fail++; $display("[TB] FAIL mid_reset_pins: got %h, want %h", o, idle_rdy); end
    n_checks++;
    if (read_data0 !== exp_rd0) begin n_fail++; $display("[TB] FAIL mid_reset_rdata: got %h, want %h", read_data0, exp_rd0); end
  endtask

  task automatic test_phase1();
    preload(1, 6'd0, 16'h4321);
    preload(1, 6'd1, 16'h8765);
    drive_request(1, 1'b0, 1'b1, 32'd1024, 32'd0);
    while (expq.size() != 0) begin
      @(negedge clk);
      e = expq.pop_front(); o = sample(1); m = '1; if (!e.chk_dq) m.dq = '0;
      n_checks++;
      if ((o & m) !== (e.s & m)) begin n_fail++; $display("[TB] FAIL phase1_seq: got %h, want %h", o, e.s); end
      if (e.s.ready) begin
        n_checks++;
        if (read_data1 !== exp_rd1) begin n_fail++; $display("[TB] FAIL phase1_data: got %h, want %h", read_data1, exp_rd1); end
      end
    end
    release_req();
  endtask

  initial begin
    idle_rdy = '{addr: 18'd0, dq: 16'd0, we_n: 1'b1, oe_n: 1'b1, dq_oe: 1'b0, ready: 1'b1};
    test_reset();
    test_read();
    test_write();
    test_write_wins();
    test_back_to_back();
    test_wrap();
    test_reset_mid_access();
    test_phase1();
    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, limit 200000", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/sram_controller.md
# sram_controller

Memory-stage initiator that replaces the single-cycle on-chip data array with an external 16-bit asynchronous SRAM. It accepts the pipeline's 32-bit load/store request (ALU result as byte address, Rm value as store data), splits it into two 16-bit SRAM accesses, and deasserts `ready` so the hazard/freeze logic stalls the pipeline until the word is complete. It sits in the MEM stage between the EXE/MEM register and the off-chip SRAM pins.

## Interface
- `BASE_ADDR`, 1024: byte address mapped to SRAM word 0.
- `PHASE_CYCLES`, 2: clock cycles each 16-bit half-access is held (≥1).
- `clk  in  1`: single clock; all state changes on the rising edge.
- `rst  in  1`: synchronous, active-high reset.
- `wr_en  in  1`: store request from MEM stage.
- `rd_en  in  1`: load request from MEM stage.
- `address  in  32`: byte address, which is the ALU result.
- `write_data  in  32`: store data, which is the Val_Rm value.
- `read_data  out  32`: loaded word, held until next load completes.
- `ready  out  1`: 0 stalls the pipeline; 1 means no access pending or access done this cycle.
- `sram_addr  out  18`: SRAM half-word address.
- `sram_dq_out  out  16`: data driven to SRAM.
- `sram_dq_oe  out  1`: 1 means the top level drives `sram_dq_out` onto the bidirectional bus.
- `sram_dq_in  in  16`: data sampled from the SRAM bus.
- `sram_we_n  out  1`: active-low write enable.
- `sram_oe_n  out  1`: active-low output enable.
- `sram_ce_n, sram_ub_n, sram_lb_n  out  1`: tied 0 (always selected, both bytes).

## Operation
- States are IDLE, LOW, HIGH and DONE.
- **IDLE**: with `wr_en|rd_en`, latch `op` (write wins if both set), `word = (address - BASE_ADDR) >> 2` and `write_data` into registers, then go to LOW. Otherwise stay.
- **LOW**: `sram_addr = {word[16:0], 1'b0}`. A write drives the latched data[15:0] with `sram_we_n=0` and `sram_dq_oe=1`. A read sets `sram_oe_n=0` and `sram_dq_oe=0`. The phase counter counts 0..PHASE_CYCLES-1. On the last count, a read captures `sram_dq_in` into `read_data[15:0]`, and the FSM moves to HIGH with the counter cleared.
- **HIGH**: same as LOW with `sram_addr = {word[16:0], 1'b1}` and data[31:16] / `read_data[31:16]`. The FSM moves to DONE on the last count.
- **DONE**: all SRAM strobes are inactive and `ready=1` for exactly one cycle. The FSM returns to IDLE unconditionally.
- `ready = (state==IDLE && !(wr_en|rd_en)) || state==DONE`, combinational from registered state and inputs.
- SRAM strobes and `sram_addr` are decoded combinationally from state and latched registers. In IDLE and DONE they are: `sram_we_n=1`, `sram_oe_n=1`, `sram_dq_oe=0`, `sram_addr=0`.
- Address arithmetic is 32-bit unsigned subtraction. Bits [1:0] of the byte address are ignored. Word index bits above 16 are dropped, so the address wraps within 128K words.
- `read_data` changes only on a read capture or reset. Writes never disturb it.

## Timing
- Reset values: state IDLE, counter 0, `read_data=0`, latched op/word/data = 0, hence `sram_we_n=1`, `sram_oe_n=1`, `sram_dq_oe=0`, `sram_addr=0`. `ready` is 1 unless a request is present.
- Request seen in IDLE at cycle 0 gives `ready=0` in cycles 0..2·PHASE_CYCLES and `ready=1` in cycle 2·PHASE_CYCLES+1 (DONE). With the default that is 5 stall cycles, ready in the 6th.
- Requests must stay stable while `ready=0`; the controller uses only the values latched at cycle 0.
- The pipeline advances on the DONE edge. A request present in the following IDLE cycle is a new access (back-to-back memory instructions), so there is no idle gap beyond that one IDLE cycle.
- Reset mid-access: on the next edge the FSM returns to IDLE and all strobes deassert. A partial write may leave the low half updated. `read_data` is cleared.

## Structure
- A shared package holds:
  - the state enum (IDLE/LOW/HIGH/DONE);
  - `BASE_ADDR`;
  - `SRAM_ADDR_W=18` and `SRAM_DATA_W=16`.
- No sub-module. The block is one FSM plus the phase counter and latch registers. The tri-state buffer lives in the board top level.

## Test plan
- Write 0xDEADBEEF at address 1028 → `sram_addr` 2 with `sram_dq_out` 0xBEEF and `sram_we_n=0` for 2 cycles, then `sram_addr` 3 with 0xDEAD. `ready` is low 5 cycles, then high 1 cycle.
- Behavioural SRAM model preloaded with half-words 2=0x5678 and 3=0x1234; read at 1028 → `read_data`=0x12345678 visible in the DONE cycle; `sram_we_n` stays 1 throughout.
- `wr_en` and `rd_en` both set at 1024 with data 0xA5A5_0F0F → write sequence performed and `read_data` unchanged.
- Back-to-back write to 1032 then read from 1032 → second access starts the cycle after DONE and returns the written word.
- Assert `rst` during the HIGH phase of a write → next cycle IDLE, `sram_we_n=1`, `read_data=0`, and `ready=1` with no request present.
- `PHASE_CYCLES=1` build, read at 1024 → `ready` low 3 cycles, word assembled from `sram_addr` 0 and 1.
